// File: rtl/conv2d_dilated_padded_engine.sv
// Single-channel 2D convolution with per-axis dilation and zero padding.
// One kernel tap is accumulated per cycle; output pixels are streamed row-major with backpressure.
module conv2d_dilated_padded_engine #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int IMG    = 8,
  parameter int KH     = 3,
  parameter int KW     = 5,
  parameter int DIL_H  = 2,
  parameter int DIL_W  = 1,
  parameter int PAD_H  = 2,
  parameter int PAD_W  = 2,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              weight_valid,
  output logic              weight_ready,
  input  logic [DATA_W-1:0] weight_data,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] input_data,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [ACC_W-1:0]  output_data
);
  localparam int OH    = (IMG + 2*PAD_H - DIL_H*(KH-1) - 1)/STRIDE + 1;
  localparam int OW    = (IMG + 2*PAD_W - DIL_W*(KW-1) - 1)/STRIDE + 1;
  localparam int NT    = KH*KW;
  localparam int NPIX  = IMG*IMG;
  localparam int CNT_W = $clog2(((NPIX > NT) ? NPIX : NT) + 1);
  localparam int WA_W  = (NT > 1) ? $clog2(NT) : 1;
  localparam int IA_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int KH_W  = $clog2(KH + 1);
  localparam int KW_W  = $clog2(KW + 1);
  localparam int OH_W  = $clog2(OH + 1);
  localparam int OW_W  = $clog2(OW + 1);
  localparam int PW    = 2*DATA_W;

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, COMPUTE, EMIT} state_t;
  state_t state_reg, state_next;

  logic [CNT_W-1:0]        cnt_reg;
  logic [KH_W-1:0]         kh_reg;
  logic [KW_W-1:0]         kw_reg;
  logic [OH_W-1:0]         oh_reg;
  logic [OW_W-1:0]         ow_reg;
  logic signed [ACC_W-1:0] acc_reg, acc_next, out_reg;
  logic                    done_reg;

  logic signed [DATA_W-1:0] weight_mem [NT];
  logic signed [DATA_W-1:0] img_mem [NPIX];

  logic w_acc, i_acc, last_tap, last_i, last_pix, emit_xfer;
  int                       ih, iw;
  logic                     in_range;
  logic [IA_W-1:0]          img_addr;
  logic signed [DATA_W-1:0] w_sel, pix;
  logic signed [PW-1:0]     prod;

  assign w_acc     = (state_reg == LOAD_W) && weight_valid;
  assign i_acc     = (state_reg == LOAD_I) && valid_in;
  assign last_tap  = (cnt_reg == CNT_W'(NT - 1));
  assign last_i    = (cnt_reg == CNT_W'(NPIX - 1));
  assign last_pix  = (oh_reg == OH_W'(OH - 1)) && (ow_reg == OW_W'(OW - 1));
  assign emit_xfer = (state_reg == EMIT) && ready_out;

  // Tap datapath: out-of-image coordinates read as zero, tap 0 restarts the sum.
  always_comb begin
    ih       = int'(oh_reg)*STRIDE - PAD_H + int'(kh_reg)*DIL_H;
    iw       = int'(ow_reg)*STRIDE - PAD_W + int'(kw_reg)*DIL_W;
    in_range = (ih >= 0) && (ih < IMG) && (iw >= 0) && (iw < IMG);
    img_addr = IA_W'(ih*IMG + iw);
    w_sel    = weight_mem[cnt_reg[WA_W-1:0]];
    pix      = in_range ? img_mem[img_addr] : '0;
    prod     = PW'(w_sel) * PW'(pix);
    acc_next = ((cnt_reg == '0) ? '0 : acc_reg) + ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    busy         = (state_reg != IDLE);
    weight_ready = (state_reg == LOAD_W);
    ready_in     = (state_reg == LOAD_I);
    valid_out    = (state_reg == EMIT);
    case (state_reg)
      IDLE:    if (start) state_next = LOAD_W;
      LOAD_W:  if (w_acc && last_tap) state_next = LOAD_I;
      LOAD_I:  if (i_acc && last_i) state_next = COMPUTE;
      COMPUTE: if (last_tap) state_next = EMIT;
      EMIT:    if (ready_out) state_next = last_pix ? IDLE : COMPUTE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      kh_reg   <= '0;
      kw_reg   <= '0;
      oh_reg   <= '0;
      ow_reg   <= '0;
      acc_reg  <= '0;
      out_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= emit_xfer && last_pix;
      case (state_reg)
        IDLE: cnt_reg <= '0;
        LOAD_W: if (w_acc) cnt_reg <= last_tap ? '0 : cnt_reg + CNT_W'(1);
        LOAD_I: begin
          if (i_acc) begin
            if (last_i) begin
              cnt_reg <= '0;
              kh_reg  <= '0;
              kw_reg  <= '0;
              oh_reg  <= '0;
              ow_reg  <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        COMPUTE: begin
          acc_reg <= acc_next;
          if (last_tap) begin
            out_reg <= acc_next;
            cnt_reg <= '0;
            kh_reg  <= '0;
            kw_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (kw_reg == KW_W'(KW - 1)) begin
              kw_reg <= '0;
              kh_reg <= kh_reg + KH_W'(1);
            end else begin
              kw_reg <= kw_reg + KW_W'(1);
            end
          end
        end
        EMIT: begin
          if (ready_out) begin
            if (ow_reg == OW_W'(OW - 1)) begin
              ow_reg <= '0;
              oh_reg <= last_pix ? '0 : oh_reg + OH_W'(1);
            end else begin
              ow_reg <= ow_reg + OW_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Coefficient and image storage survive IDLE; only a new load overwrites them.
  always_ff @(posedge clk) begin
    if (w_acc) weight_mem[cnt_reg[WA_W-1:0]] <= weight_data;
    if (i_acc) img_mem[cnt_reg[IA_W-1:0]] <= input_data;
  end

  assign done        = done_reg;
  assign output_data = out_reg;
endmodule

// File: tb/tb_conv2d_dilated_padded_engine.sv
// Directed bench for conv2d_dilated_padded_engine with default parameters (8x8 image, 3x5 kernel).
module tb_conv2d_dilated_padded_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic        weight_valid = 1'b0;
  logic        weight_ready;
  logic [15:0] weight_data = '0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [15:0] input_data = '0;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic [39:0] output_data;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] res [64];
  int          n_out, n_done, lat, k, nz, nz_ok;
  logic [63:0] sum;

  conv2d_dilated_padded_engine dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .weight_valid(weight_valid), .weight_ready(weight_ready), .weight_data(weight_data),
    .valid_in(valid_in), .ready_in(ready_in), .input_data(input_data),
    .valid_out(valid_out), .ready_out(ready_out), .output_data(output_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_weight_ready"}, 64'(weight_ready), 64'd0);
    check({tag, "_ready_in"}, 64'(ready_in), 64'd0);
    check({tag, "_valid_out"}, 64'(valid_out), 64'd0);
    check({tag, "_output_data"}, 64'(output_data), 64'd0);
  endtask

  // mode 0: all ones; mode 1: weights 1..15 and an impulse at (3,3); mode 2: all -32768
  function automatic logic [15:0] gen(input int mode, input int idx, input bit is_img);
    if (mode == 0) return 16'd1;
    if (mode == 1) return is_img ? ((idx == 27) ? 16'd1 : 16'd0) : 16'(idx + 1);
    return 16'h8000;
  endfunction

  task automatic load(input int mode, input bit glitch, input int abort_at, output int lat_o);
    lat_o = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      weight_valid = 1'b1; weight_data = gen(mode, i, 1'b0);
      @(negedge clk);
    end
    weight_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      if (i == 20) begin
        valid_in = 1'b0;
        @(negedge clk);
      end
      valid_in = 1'b1; input_data = gen(mode, i, 1'b1);
      if (glitch && i == 5) start = 1'b1;
      if (i == abort_at) begin
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs("midload_rst");
        @(negedge clk);
        rst = 1'b0; valid_in = 1'b0;
        $display("load mode %0d aborted by reset at sample %0d", mode, i);
        return;
      end
      @(negedge clk);
      start = 1'b0;
    end
    valid_in = 1'b0;
    lat_o = 1;
    if (glitch) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat_o++;
    end
    while (!valid_out && lat_o < 200) begin
      @(negedge clk);
      lat_o++;
    end
    $display("load mode %0d done, first valid_out after %0d cycles", mode, lat_o);
  endtask

  task automatic collect(output int n_o, output int n_d);
    n_o = 0; n_d = 0;
    for (int c = 0; c < 2000 && n_d == 0; c++) begin
      if (valid_out && ready_out) begin
        if (n_o < 64) res[n_o] = output_data;
        $display("out %0d = %0d", n_o, $signed(output_data));
        n_o++;
      end
      if (done) n_d++;
      else @(negedge clk);
    end
    check("idle_at_done", 64'(busy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) n_d++;
    end
  endtask

  initial begin
    #2 check_reset_outputs("por");
    @(negedge clk); rst = 1'b0;

    // All ones
    load(0, 1'b0, -1, lat);
    check("ones_latency", 64'(lat), 64'd16);
    collect(n_out, n_done);
    check("ones_count", 64'(n_out), 64'd64);
    check("ones_done", 64'(n_done), 64'd1);
    check("ones_0_0", 64'(res[0]), 64'd6);
    check("ones_0_4", 64'(res[4]), 64'd10);
    check("ones_4_4", 64'(res[36]), 64'd15);
    check("ones_7_7", 64'(res[63]), 64'd6);

    // Ramp weights, impulse image
    load(1, 1'b0, -1, lat);
    collect(n_out, n_done);
    check("imp_count", 64'(n_out), 64'd64);
    check("imp_1_3", 64'(res[11]), 64'd13);
    check("imp_5_5", 64'(res[45]), 64'd1);
    check("imp_3_1", 64'(res[25]), 64'd10);
    nz = 0; nz_ok = 0; sum = '0;
    for (int p = 0; p < 64; p++) begin
      if (res[p] != '0) begin
        nz++;
        sum += 64'(res[p]);
        if ((p / 8) % 2 == 1 && (p / 8) <= 5 && (p % 8) >= 1 && (p % 8) <= 5) nz_ok++;
      end
    end
    check("imp_nonzero", 64'(nz), 64'd15);
    check("imp_nonzero_pos", 64'(nz_ok), 64'd15);
    check("imp_sum", sum, 64'd120);

    // Most negative operands
    load(2, 1'b0, -1, lat);
    collect(n_out, n_done);
    check("neg_0_0", 64'(res[0]), 64'h1_8000_0000);
    check("neg_4_4", 64'(res[36]), 64'h3_C000_0000);

    // Backpressure on the first pixel
    ready_out = 1'b0;
    load(0, 1'b0, -1, lat);
    check("bp_latency", 64'(lat), 64'd16);
    check("bp_first", 64'(output_data), 64'd6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(valid_out), 64'd1);
      check("bp_hold_data", 64'(output_data), 64'd6);
    end
    ready_out = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!valid_out && k < 200);
    check("bp_next_latency", 64'(k), 64'd16);
    check("bp_0_1", 64'(output_data), 64'd8);
    collect(n_out, n_done);
    check("bp_count", 64'(n_out), 64'd63);
    check("bp_done", 64'(n_done), 64'd1);
    check("bp_4_4", 64'(res[35]), 64'd15);

    // Reset during the 10th image accept, then a full reload
    load(0, 1'b0, 9, lat);
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    load(0, 1'b0, -1, lat);
    collect(n_out, n_done);
    check("rst_reload_count", 64'(n_out), 64'd64);
    check("rst_reload_0_0", 64'(res[0]), 64'd6);
    check("rst_reload_4_4", 64'(res[36]), 64'd15);

    // start pulses during LOAD_I and COMPUTE are ignored
    load(1, 1'b1, -1, lat);
    check("glitch_latency", 64'(lat), 64'd16);
    collect(n_out, n_done);
    check("glitch_count", 64'(n_out), 64'd64);
    check("glitch_done", 64'(n_done), 64'd1);
    check("glitch_1_3", 64'(res[11]), 64'd13);
    check("glitch_5_5", 64'(res[45]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
